rnn_rr_sched: RTL and testbench



---
 rtl/rnn_pkg.sv | 23 ++
 rtl/rnn_rr_arb.sv | 34 +++
 rtl/rnn_rr_sched.sv | 103 ++++++++++
 tb/tb_rnn_rr_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// Shared types, constants and arithmetic helpers for the recurrent accumulate scheduler.
package rnn_pkg;

    localparam int DATA_W_DEF = 32'd8;
    localparam int NCH_MAX    = 32'd8;

    typedef logic [7:0] rnn_data_t;

    // Unsigned add clamped to the all-ones value of a w-bit field (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum_s;
        logic [32:0] max_s;
        sum_s = {1'b0, a} + {1'b0, b};
        max_s = (33'd1 << w) - 33'd1;
        if (sum_s > max_s) begin
            return max_s[31:0];
        end else begin
            return sum_s[31:0];
        end
    endfunction

endpackage

// File: rtl/rnn_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rnn_rr_arb #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx
);

    localparam int IW = $clog2(NCH);

    logic found_s;
    int   cand_s;

    // Scan requesters in rotating order starting from the pointer.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NCH; k++) begin
            cand_s = (int'(ptr) + k) % NCH;
            if (!found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = IW'(cand_s);
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rnn_rr_sched.sv
// Time-multiplexed accumulate cell shared by NCH channels with per-channel state and step count.
// Build option: define RNN_SCHED_SAT_EN to saturate the sum instead of wrapping.
import rnn_pkg::*;

module rnn_rr_sched #(
    parameter int NCH     = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEQ_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          req_valid,
    input  logic [NCH*DATA_W-1:0]   req_data,
    output logic [NCH-1:0]          req_ready,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last
);

    localparam int IW = $clog2(NCH);
    localparam int CW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic [IW-1:0]     ptr_r;
    logic [DATA_W-1:0] state_r [NCH];
    logic [CW-1:0]     cnt_r   [NCH];

    logic [NCH-1:0]    gnt_s;
    logic [IW-1:0]     gidx_s;
    logic [DATA_W-1:0] cur_s;
    logic [DATA_W-1:0] sum_s;
    logic              last_s;
    logic              slot_free_s;
    logic              xfer_s;

    rnn_rr_arb #(.NCH(NCH)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gidx_s)
    );

    // Shared update datapath and handshake for the granted channel.
    always_comb begin
        cur_s = req_data[int'(gidx_s)*DATA_W +: DATA_W];
`ifdef RNN_SCHED_SAT_EN
        sum_s = DATA_W'(sat_add(32'(state_r[gidx_s]), 32'(cur_s), DATA_W));
`else
        sum_s = state_r[gidx_s] + cur_s;
`endif
        last_s      = (cnt_r[gidx_s] == CW'(SEQ_LEN - 1));
        slot_free_s = !out_valid || out_ready;
        if (slot_free_s && !clr) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
        xfer_s = |(req_valid & req_ready);
    end

    // Channel state, step counters, RR pointer and the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= '0;
                cnt_r[i]   <= '0;
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < NCH; i++) begin
                    state_r[i] <= '0;
                    cnt_r[i]   <= '0;
                end
            end else if (xfer_s) begin
                if (last_s) begin
                    state_r[gidx_s] <= '0;
                    cnt_r[gidx_s]   <= '0;
                end else begin
                    state_r[gidx_s] <= sum_s;
                    cnt_r[gidx_s]   <= cnt_r[gidx_s] + CW'(1);
                end
            end
            // A pending result survives clr; only a downstream accept retires it.
            if (xfer_s) begin
                ptr_r     <= (gidx_s == IW'(NCH - 1)) ? '0 : gidx_s + IW'(1);
                out_valid <= 1'b1;
                out_ch    <= gidx_s;
                out_data  <= sum_s;
                out_last  <= last_s;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rnn_rr_sched.sv
// Directed self-checking bench for rnn_rr_sched (NCH=4, DATA_W=8, SEQ_LEN=16).
module tb_rnn_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [7:0]  out_data;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    rnn_rr_sched #(.NCH(4), .DATA_W(8), .SEQ_LEN(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'd0;
        req_data  = 32'd0;
        clr       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    // Drive one channel's request, check grant, then check the registered result.
    task automatic send(input int ch, input logic [7:0] d, input logic [7:0] exp_d,
                        input logic exp_last, input string tag);
        req_valid = 4'd0;
        req_valid[ch] = 1'b1;
        req_data = 32'd0;
        req_data[ch*8 +: 8] = d;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1 << ch);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ch"}, 32'(out_ch), 32'(ch));
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_last"}, 32'(out_last), 32'(exp_last));
        req_valid = 4'd0;
    endtask

    logic [7:0] seq_d [3];
    logic [7:0] seq_e [3];

    initial begin
        seq_d[0] = 8'd3; seq_d[1] = 8'd5; seq_d[2] = 8'd7;
        seq_e[0] = 8'd3; seq_e[1] = 8'd8; seq_e[2] = 8'd15;

        do_reset();

        // Single channel accumulate
        for (int k = 0; k < 3; k++) send(0, seq_d[k], seq_e[k], 1'b0, "single");
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Fairness from a fresh pointer
        do_reset();
        req_valid = 4'hF;
        req_data  = 32'h01010101;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fair_ready", 32'(req_ready), 32'd1 << (k % 4));
            tick();
            check("fair_ch", 32'(out_ch), 32'(k % 4));
            check("fair_data", 32'(out_data), (k < 4) ? 32'd1 : 32'd2);
        end
        req_valid = 4'd0;
        tick();

        // Sequence end and auto-clear
        do_reset();
        for (int k = 0; k < 16; k++) send(2, 8'd1, 8'(k + 1), (k == 15), "seq");
        send(2, 8'd4, 8'd4, 1'b0, "seq_after");

        // Backpressure
        do_reset();
        send(1, 8'd6, 8'd6, 1'b0, "bp_first");
        out_ready = 1'b0;
        req_valid = 4'b0010;
        req_data  = 32'h00000200;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready_blocked", 32'(req_ready), 32'd0);
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'd6);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0010);
        tick();
        check("bp_release_data", 32'(out_data), 32'd8);
        check("bp_release_valid", 32'(out_valid), 32'd1);
        req_valid = 4'd0;

        // Clear collision, pending result survives clr
        do_reset();
        send(0, 8'd5, 8'd5, 1'b0, "clr_pre0");
        send(3, 8'd7, 8'd7, 1'b0, "clr_pre3");
        out_ready = 1'b0;
        clr       = 1'b1;
        req_valid = 4'b1001;
        req_data  = 32'h09000009;
        #1;
        check("clr_ready", 32'(req_ready), 32'd0);
        tick();
        check("clr_keep_valid", 32'(out_valid), 32'd1);
        check("clr_keep_data", 32'(out_data), 32'd7);
        clr       = 1'b0;
        out_ready = 1'b1;
        send(0, 8'd9, 8'd9, 1'b0, "clr_post0");
        send(3, 8'd1, 8'd1, 1'b0, "clr_post3");

        // Overflow
        do_reset();
        send(0, 8'd250, 8'd250, 1'b0, "ovf_pre");
`ifdef RNN_SCHED_SAT_EN
        send(0, 8'd10, 8'd255, 1'b0, "ovf");
`else
        send(0, 8'd10, 8'd4, 1'b0, "ovf");
`endif

        // Reset mid-operation discards the pending result
        out_ready = 1'b0;
        tick();
        check("mid_pending", 32'(out_valid), 32'd1);
        do_reset();
        send(0, 8'd2, 8'd2, 1'b0, "mid_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
